bisr_job_scheduler: RTL and testbench

Top-level sequencer for the weight-proxy BISR systolic subsystem. Serialises host matmul jobs onto the matmul FSM/output-control handshakes. Interleaves mandatory stop-the-world (STW) self-tests at power-on, every TEST_PERIOD completed jobs, and on demand. Accumulates a sticky PE fault map and halts the array once a column holds more faults than its single weight proxy can repair.

---
 rtl/bisr_sched_pkg.sv | 25 ++
 rtl/bisr_fault_accum.sv | 62 ++++++
 rtl/bisr_job_scheduler.sv | 164 ++++++++++++++++
 tb/tb_bisr_job_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bisr_sched_pkg.sv
// Shared types and helpers for the BISR job scheduler: FSM state encoding,
// fault-count width and result-matrix bit indexing (col*ROWS+row).
package bisr_sched_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        TEST_START = 4'd1,
        TEST_WAIT  = 4'd2,
        LOAD_START = 4'd3,
        LOAD_WAIT  = 4'd4,
        MM_START   = 4'd5,
        MM_WAIT    = 4'd6,
        HALT       = 4'd7,
        ERR        = 4'd8
    } sched_state_t;

    function automatic int fault_cnt_w(input int n_pe);
        return $clog2(n_pe + 1);
    endfunction

    function automatic int res_idx(input int col, input int row, input int rows);
        return col * rows + row;
    endfunction

endpackage

// File: rtl/bisr_fault_accum.sv
// Sticky PE fault map with registered popcount and a look-ahead flag that
// reports whether the map after the pending update has any column with >=2 faults.
module bisr_fault_accum
    import bisr_sched_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                upd_i,
    input  logic [ROWS*COLS-1:0]                result_i,
    output logic [ROWS*COLS-1:0]                fault_map_o,
    output logic [fault_cnt_w(ROWS*COLS)-1:0]   fault_count_o,
    output logic                                next_col_fail_o
);

    localparam int CW = fault_cnt_w(ROWS * COLS);

    logic [ROWS*COLS-1:0] map_q, map_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 col_fail;

    always_comb begin
        int col_cnt;
        map_d    = map_q;
        col_fail = 1'b0;
        count_d  = '0;
        col_cnt  = 0;
        if (upd_i) begin
            map_d = map_q | result_i;
        end
        for (int c = 0; c < COLS; c++) begin
            col_cnt = 0;
            for (int r = 0; r < ROWS; r++) begin
                col_cnt = col_cnt + int'(map_d[res_idx(c, r, ROWS)]);
            end
            if (col_cnt >= 2) begin
                col_fail = 1'b1;
            end
        end
        // Count lags the map by one cycle to keep the adder off the update path.
        for (int i = 0; i < ROWS * COLS; i++) begin
            count_d = count_d + CW'(map_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            map_q   <= '0;
            count_q <= '0;
        end else begin
            map_q   <= map_d;
            count_q <= count_d;
        end
    end

    assign fault_map_o     = map_q;
    assign fault_count_o   = count_q;
    assign next_col_fail_o = col_fail;

endmodule

// File: rtl/bisr_job_scheduler.sv
// Serialises host matmul jobs and interleaves stop-the-world self-tests.
// Optional watchdog on wait states: define BISR_SCHED_WATCHDOG_EN.
module bisr_job_scheduler
    import bisr_sched_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int TEST_PERIOD    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                job_req,
    input  logic                                force_test,
    input  logic                                fsm_rdy,
    input  logic                                wr_output_done,
    input  logic                                STW_complete,
    input  logic [ROWS*COLS-1:0]                STW_result_mat,
    output logic                                start_fsm,
    output logic                                start_matmul,
    output logic                                stw_start,
    output logic                                job_ack,
    output logic                                job_done,
    output logic                                busy,
    output logic [ROWS*COLS-1:0]                fault_map,
    output logic [fault_cnt_w(ROWS*COLS)-1:0]   fault_count,
    output logic                                unrepairable,
    output logic                                timeout_err
);

    localparam int JCW = $clog2(TEST_PERIOD + 1);

    if (TEST_PERIOD < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("bisr_job_scheduler: TEST_PERIOD and TIMEOUT_CYCLES must be >= 1");
    end

    sched_state_t   state_q, state_d;
    logic           pend_q, pend_d;
    logic [JCW-1:0] cnt_q, cnt_d;
    logic           accum_upd, next_col_fail;
    logic           stw_start_q, start_fsm_q, job_ack_q, start_matmul_q;
    logic           job_done_q, busy_q, unrep_q;

`ifdef BISR_SCHED_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_q, wd_d;
    logic           tmo_q;
`endif

    bisr_fault_accum #(.ROWS(ROWS), .COLS(COLS)) u_accum (
        .clk             (clk),
        .rst             (rst),
        .upd_i           (accum_upd),
        .result_i        (STW_result_mat),
        .fault_map_o     (fault_map),
        .fault_count_o   (fault_count),
        .next_col_fail_o (next_col_fail)
    );

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        accum_upd = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q)       state_d = TEST_START;
                else if (job_req) state_d = LOAD_START;
            end
            TEST_START: state_d = TEST_WAIT;
            TEST_WAIT: begin
                if (STW_complete) begin
                    accum_upd = 1'b1;
                    pend_d    = 1'b0;
                    state_d   = next_col_fail ? HALT : IDLE;
                end
            end
            LOAD_START: state_d = LOAD_WAIT;
            LOAD_WAIT: begin
                if (fsm_rdy) state_d = MM_START;
            end
            MM_START: state_d = MM_WAIT;
            MM_WAIT: begin
                if (wr_output_done) begin
                    state_d = IDLE;
                    if (cnt_q == JCW'(TEST_PERIOD - 1)) begin
                        cnt_d  = '0;
                        pend_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HALT:    state_d = HALT;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase

        // Applied after the TEST_WAIT clear so a request landing on STW_complete survives.
        if (force_test && state_q != HALT && state_q != ERR) begin
            pend_d = 1'b1;
        end

`ifdef BISR_SCHED_WATCHDOG_EN
        wd_d = wd_q;
        if (state_d != state_q) begin
            wd_d = WDW'(TIMEOUT_CYCLES - 1);
        end else if (state_q == TEST_WAIT || state_q == LOAD_WAIT || state_q == MM_WAIT) begin
            if (wd_q == '0) state_d = ERR;
            else            wd_d = wd_q - 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            pend_q         <= 1'b1;
            cnt_q          <= '0;
            stw_start_q    <= 1'b0;
            start_fsm_q    <= 1'b0;
            job_ack_q      <= 1'b0;
            start_matmul_q <= 1'b0;
            job_done_q     <= 1'b0;
            busy_q         <= 1'b0;
            unrep_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            pend_q         <= pend_d;
            cnt_q          <= cnt_d;
            stw_start_q    <= (state_d == TEST_START);
            start_fsm_q    <= (state_d == LOAD_START);
            job_ack_q      <= (state_d == LOAD_START);
            start_matmul_q <= (state_d == MM_START);
            job_done_q     <= (state_q == MM_WAIT) && (state_d == IDLE);
            busy_q         <= (state_d != IDLE);
            unrep_q        <= unrep_q | (state_d == HALT);
        end
    end

`ifdef BISR_SCHED_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            tmo_q <= tmo_q | (state_d == ERR);
        end
    end
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign stw_start    = stw_start_q;
    assign start_fsm    = start_fsm_q;
    assign job_ack      = job_ack_q;
    assign start_matmul = start_matmul_q;
    assign job_done     = job_done_q;
    assign busy         = busy_q;
    assign unrepairable = unrep_q;

endmodule

// File: tb/tb_bisr_job_scheduler.sv
// Directed bench for bisr_job_scheduler (TEST_PERIOD=2, TIMEOUT_CYCLES=16).
// Outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_bisr_job_scheduler;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int N    = ROWS * COLS;

    logic          clk = 1'b0;
    logic          rst;
    logic          job_req, force_test, fsm_rdy, wr_output_done, STW_complete;
    logic [N-1:0]  STW_result_mat;
    logic          start_fsm, start_matmul, stw_start, job_ack, job_done, busy;
    logic [N-1:0]  fault_map;
    logic [4:0]    fault_count;
    logic          unrepairable, timeout_err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bisr_job_scheduler #(
        .ROWS(ROWS), .COLS(COLS), .TEST_PERIOD(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .job_req        (job_req),
        .force_test     (force_test),
        .fsm_rdy        (fsm_rdy),
        .wr_output_done (wr_output_done),
        .STW_complete   (STW_complete),
        .STW_result_mat (STW_result_mat),
        .start_fsm      (start_fsm),
        .start_matmul   (start_matmul),
        .stw_start      (stw_start),
        .job_ack        (job_ack),
        .job_done       (job_done),
        .busy           (busy),
        .fault_map      (fault_map),
        .fault_count    (fault_count),
        .unrepairable   (unrepairable),
        .timeout_err    (timeout_err)
    );

    // Counts falling edges until the selected output is high; -1 if never within limit.
    // which: 0 stw_start, 1 start_fsm, 2 start_matmul, 3 job_done
    task automatic wait_sig(input int which, input int limit, output int cyc);
        logic hit;
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = stw_start;
                1:       hit = start_fsm;
                2:       hit = start_matmul;
                default: hit = job_done;
            endcase
            if (hit === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Called while in TEST_START; completes the self-test with the given result.
    task automatic finish_test(input logic [N-1:0] mat);
        @(negedge clk);
        STW_complete   = 1'b1;
        STW_result_mat = mat;
        @(negedge clk);
        STW_complete   = 1'b0;
        STW_result_mat = '0;
    endtask

    task automatic run_job(output int c_fsm, output int c_mm, output int c_done);
        wait_sig(1, 5, c_fsm);
        @(negedge clk);
        fsm_rdy = 1'b1;
        wait_sig(2, 5, c_mm);
        fsm_rdy = 1'b0;
        @(negedge clk);
        wr_output_done = 1'b1;
        wait_sig(3, 5, c_done);
        wr_output_done = 1'b0;
    endtask

    task automatic test_reset();
        int c;
        rst = 1'b0;
        job_req = 0; force_test = 0; fsm_rdy = 0; wr_output_done = 0;
        STW_complete = 0; STW_result_mat = '0;
        repeat (3) @(negedge clk);
        total++; if ({stw_start, start_fsm, job_ack, start_matmul, job_done} !== 5'b0)
            $display("FAIL reset_pulses: got %b want 00000", {stw_start, start_fsm, job_ack, start_matmul, job_done}); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (fault_map !== '0) $display("FAIL reset_fault_map: got %h want 0000", fault_map); else passed++;
        total++; if (fault_count !== 5'd0) $display("FAIL reset_fault_count: got %0d want 0", fault_count); else passed++;
        total++; if ({unrepairable, timeout_err} !== 2'b00)
            $display("FAIL reset_sticky: got %b want 00", {unrepairable, timeout_err}); else passed++;
        rst = 1'b1;
        job_req = 1'b1;
        wait_sig(0, 5, c);
        total++; if (c !== 1) $display("FAIL first_stw_latency: got %0d want 1", c); else passed++;
        total++; if (start_fsm !== 1'b0) $display("FAIL test_before_job: start_fsm got %b want 0", start_fsm); else passed++;
    endtask

    task automatic test_basic_job();
        int c;
        finish_test('0);
        total++; if (busy !== 1'b0) $display("FAIL basic_idle_after_test: busy got %b want 0", busy); else passed++;
        wait_sig(1, 5, c);
        total++; if (c !== 1) $display("FAIL basic_start_fsm: got %0d want 1", c); else passed++;
        total++; if (job_ack !== 1'b1) $display("FAIL basic_job_ack: got %b want 1", job_ack); else passed++;
        @(negedge clk);
        total++; if ({start_fsm, job_ack} !== 2'b00) $display("FAIL basic_pulse_width: got %b want 00", {start_fsm, job_ack}); else passed++;
        fsm_rdy = 1'b1;
        wait_sig(2, 5, c);
        fsm_rdy = 1'b0;
        total++; if (c !== 1) $display("FAIL basic_start_matmul: got %0d want 1", c); else passed++;
        @(negedge clk);
        wr_output_done = 1'b1;
        wait_sig(3, 5, c);
        wr_output_done = 1'b0;
        total++; if (c !== 1) $display("FAIL basic_job_done: got %0d want 1", c); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL basic_idle_after_job: busy got %b want 0", busy); else passed++;
        total++; if (fault_count !== 5'd0) $display("FAIL basic_fault_count: got %0d want 0", fault_count); else passed++;
    endtask

    task automatic test_periodic();
        int cf, cm, cd, c;
        run_job(cf, cm, cd);
        total++; if ({cf, cm, cd} !== {32'd1, 32'd1, 32'd1})
            $display("FAIL period_job2: got %0d/%0d/%0d want 1/1/1", cf, cm, cd); else passed++;
        wait_sig(0, 5, c);
        total++; if (c !== 1) $display("FAIL period_test_due: got %0d want 1", c); else passed++;
        total++; if (start_fsm !== 1'b0) $display("FAIL period_test_first: start_fsm got %b want 0", start_fsm); else passed++;
        finish_test('0);
        run_job(cf, cm, cd);
        total++; if (cf !== 1) $display("FAIL period_job3_direct: got %0d want 1", cf); else passed++;
        run_job(cf, cm, cd);
        total++; if (cf !== 1) $display("FAIL period_job4_no_test: got %0d want 1", cf); else passed++;
        wait_sig(0, 5, c);
        total++; if (c !== 1) $display("FAIL period_wrap_retest: got %0d want 1", c); else passed++;
        finish_test('0);
    endtask

    task automatic test_force_test();
        int c;
        logic stw_seen;
        wait_sig(1, 5, c);
        @(negedge clk);
        fsm_rdy = 1'b1;
        wait_sig(2, 5, c);
        fsm_rdy = 1'b0;
        @(negedge clk);
        force_test = 1'b1;
        @(negedge clk);
        force_test = 1'b0;
        stw_seen = stw_start;
        repeat (3) begin
            @(negedge clk);
            stw_seen = stw_seen | stw_start;
        end
        total++; if ({stw_seen, job_done, busy} !== 3'b001)
            $display("FAIL force_no_abort: stw/done/busy got %b want 001", {stw_seen, job_done, busy}); else passed++;
        wr_output_done = 1'b1;
        wait_sig(3, 5, c);
        wr_output_done = 1'b0;
        total++; if (c !== 1) $display("FAIL force_job_done: got %0d want 1", c); else passed++;
        wait_sig(0, 5, c);
        total++; if (c !== 1) $display("FAIL force_stw_next: got %0d want 1", c); else passed++;
        total++; if (start_fsm !== 1'b0) $display("FAIL force_before_job: start_fsm got %b want 0", start_fsm); else passed++;
    endtask

    task automatic test_fault_halt();
        int cf, cm, cd, c;
        finish_test(16'h0042);
        run_job(cf, cm, cd);
        total++; if (cf !== 1) $display("FAIL fault_jobs_continue: got %0d want 1", cf); else passed++;
        total++; if (fault_map !== 16'h0042) $display("FAIL fault_map_1: got %h want 0042", fault_map); else passed++;
        total++; if (fault_count !== 5'd2) $display("FAIL fault_count_1: got %0d want 2", fault_count); else passed++;
        total++; if (unrepairable !== 1'b0) $display("FAIL fault_repairable: got %b want 0", unrepairable); else passed++;
        wait_sig(0, 5, c);
        total++; if (c !== 1) $display("FAIL fault_retest: got %0d want 1", c); else passed++;
        finish_test(16'h0008);
        repeat (2) @(negedge clk);
        total++; if (unrepairable !== 1'b1) $display("FAIL halt_unrepairable: got %b want 1", unrepairable); else passed++;
        total++; if (fault_map !== 16'h004A) $display("FAIL fault_map_2: got %h want 004a", fault_map); else passed++;
        total++; if (fault_count !== 5'd3) $display("FAIL fault_count_2: got %0d want 3", fault_count); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL halt_busy: got %b want 1", busy); else passed++;
        wait_sig(1, 20, c);
        total++; if (c !== -1) $display("FAIL halt_ignores_job: start_fsm after %0d want none", c); else passed++;
        force_test = 1'b1;
        @(negedge clk);
        force_test = 1'b0;
        wait_sig(0, 10, c);
        total++; if (c !== -1) $display("FAIL halt_ignores_force: stw_start after %0d want none", c); else passed++;
    endtask

    task automatic test_reset_mid_job();
        int c;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wait_sig(0, 5, c);
        total++; if (c !== 1) $display("FAIL rst_recover_stw: got %0d want 1", c); else passed++;
        finish_test('0);
        wait_sig(1, 5, c);
        @(negedge clk);
        fsm_rdy = 1'b1;
        wait_sig(2, 5, c);
        fsm_rdy = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy); else passed++;
        #2 rst = 1'b0;
        #1;
        total++; if ({busy, start_fsm, start_matmul, stw_start, job_ack, job_done, unrepairable} !== 7'b0)
            $display("FAIL mid_async_reset: got %b want 0000000",
                     {busy, start_fsm, start_matmul, stw_start, job_ack, job_done, unrepairable}); else passed++;
        total++; if (fault_map !== '0) $display("FAIL mid_fault_map: got %h want 0000", fault_map); else passed++;
        @(negedge clk);
        rst = 1'b1;
        wait_sig(0, 5, c);
        total++; if (c !== 1) $display("FAIL mid_stw_reissued: got %0d want 1", c); else passed++;
    endtask

    task automatic test_load_wait();
        int c;
        finish_test('0);
        wait_sig(1, 5, c);
        job_req = 1'b0;
        total++; if (c !== 1) $display("FAIL lw_start_fsm: got %0d want 1", c); else passed++;
`ifdef BISR_SCHED_WATCHDOG_EN
        repeat (16) @(negedge clk);
        total++; if (timeout_err !== 1'b0) $display("FAIL wd_early: got %b want 0", timeout_err); else passed++;
        @(negedge clk);
        total++; if (timeout_err !== 1'b1) $display("FAIL wd_timeout: got %b want 1", timeout_err); else passed++;
        fsm_rdy = 1'b1;
        wait_sig(2, 5, c);
        fsm_rdy = 1'b0;
        total++; if (c !== -1) $display("FAIL wd_err_stuck: start_matmul after %0d want none", c); else passed++;
`else
        repeat (1000) @(negedge clk);
        total++; if ({busy, timeout_err} !== 2'b10) $display("FAIL lw_still_waiting: busy/tmo got %b want 10", {busy, timeout_err}); else passed++;
        fsm_rdy = 1'b1;
        wait_sig(2, 5, c);
        fsm_rdy = 1'b0;
        total++; if (c !== 1) $display("FAIL lw_resume: got %0d want 1", c); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_basic_job();
        test_periodic();
        test_force_test();
        test_fault_halt();
        test_reset_mid_job();
        test_load_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
